des_iter_core: RTL and testbench
================================

Name: des_iter_core

Overview:
- Iterative DES encrypt/decrypt engine, one Feistel round per clock, 16 rounds per 64-bit block.
- Sits directly upstream of the S-box leaf modules des_s1..des_s8 and instantiates all eight.
- Each round, the 48-bit (E(R) xor Kn) word is split into eight 6-bit groups, one per S-box; the 32-bit S-box output is P-permuted.
- Owns IP/FP, PC-1/PC-2 key schedule, round counter and start/done handshake.

Parameters:
- None. The algorithm is fixed to FIPS 46-3 DES.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request: load a new block; honoured only when busy=0
- decrypt  input  1  0=encrypt, 1=decrypt; sampled with start
- key  input  64  DES key; bit 63 = FIPS bit 1; parity bits ignored; sampled with start
- din  input  64  plaintext or ciphertext; bit 63 = FIPS bit 1; sampled with start
- busy  output  1  high while rounds are in progress
- done  output  1  one-cycle pulse when dout is updated
- dout  output  64  result, bit 63 = FIPS bit 1; held until the next completion

Behaviour:
- Reset (async, rst_n=0):
  - busy=0, done=0, dout=0.
  - L, R, C, D, round counter and latched mode are cleared.
  - FSM goes to IDLE.
  - Asserting reset mid-operation aborts the block; no done is produced.
- FSM states: IDLE, RUN.
- IDLE, start=1 at edge T0:
  - L||R <= IP(din); C||D <= PC1(key).
  - mode <= decrypt; cnt <= 0; busy <= 1; go to RUN.
- IDLE, start=0: hold state; done <= 0.
- RUN, each edge T1..T16 performs round n=cnt+1:
  - L' = R; R' = L xor P(S(E(R) xor Kn)).
  - cnt increments.
- RUN, edge T16 (cnt=15):
  - dout <= FP(R'||L') (swap after last round); done <= 1; busy <= 0; go to IDLE.
  - Latency: done is high in the cycle after T16, i.e. 16 clocks after the start edge.
- done is 1 for exactly one cycle. start sampled in that cycle is accepted, giving back-to-back blocks every 17 cycles.
- start while busy=1 is ignored; key/din/decrypt changes during RUN have no effect.
- Key schedule, shift table s = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1:
  - Encrypt: round n uses PC2 of (C,D) rotated left by s[n]. The rotated value is registered for the next round; the rotation is computed combinationally before PC2.
  - Decrypt: round 1 uses PC2(C0||D0) with no rotation (equal to K16). After round j (1..15), C and D each rotate right by s[17-j]. Round n therefore uses K(17-n).
- S-box interface:
  - 48-bit word bits [47:42] go to des_s1, then onward in order to [5:0] for des_s8.
  - Each 6-bit group is passed MSB-first in FIPS b1..b6 order, unmodified. Outer bits b1,b6 select the row; b2..b5 select the column. The S-box modules decode internally.
  - S-box outputs concatenate s1 (MSB) .. s8 (LSB) before P.
- All permutations (IP, FP, E, P, PC1, PC2) are pure wiring; no arithmetic.
- Only the round datapath register sits in the loop: a single-cycle combinational path E→xor→S→P→xor.

Test Plan:
- Encrypt: key=133457799BBCDFF1, din=0123456789ABCDEF, start 1 cycle -> done pulses 16 clocks after start edge, dout=85E813540F0AB405, busy high exactly 16 cycles.
- Decrypt: same key, din=85E813540F0AB405, decrypt=1 -> dout=0123456789ABCDEF.
- Encrypt: key=0E329232EA6D0D73, din=8787878787878787 -> dout=0000000000000000. Flip key parity bits (LSB of each byte) -> same result.
- Busy protection: start pulsed with different din/key at rounds 3 and 10 -> ignored; result matches first block; done pulses once.
- Back-to-back: start held high through the done cycle with the next vector -> second done exactly 17 cycles after first. dout holds the first result until then.
- Reset abort: rst_n low at round 8 -> busy=0, done=0, dout=0 immediately (asynchronous). Subsequent start yields the correct result, with no spurious done.

Source files
------------

// File: rtl/des_iter_core.sv
`default_nettype none
// ============================================================================
//  Module      : des_iter_core (with S-box leaves des_s1 .. des_s8)
//  Description : Iterative FIPS 46-3 DES encrypt/decrypt engine. One Feistel
//                round per clock and 16 rounds per 64-bit block. The engine
//                contains the IP/FP permutations, the PC-1/PC-2 key schedule,
//                the round counter and the start/done handshake.
//
//  Ports       : clk      - system clock, all state on the rising edge
//                rst_n    - asynchronous active-low reset
//                start    - load a new block (honoured only while busy=0)
//                decrypt  - 0 = encrypt, 1 = decrypt (sampled with start)
//                key[63:0]- DES key, bit 63 = FIPS bit 1, parity ignored
//                din[63:0]- input block, bit 63 = FIPS bit 1
//                busy     - high while rounds are in progress
//                done     - one-cycle pulse when dout is updated
//                dout[63:0]- result, held until the next completion
//
//  Revision    : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// S-box leaves. Each table lists the 64 entries row-major (row = b1b6,
// column = b2..b5); entry 0 sits in the top nibble. Because the table is
// indexed from the MSB end, the nibble offset is the bitwise inverse of the
// 6-bit {row,col} index.
// ----------------------------------------------------------------------------
module des_s1 (
    input  logic [5:0] i_sel,
    output logic [3:0] o_val
);
    localparam logic [255:0] C_TBL = {64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538,
                                      64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D};
    logic [5:0] w_idx_n;
    assign w_idx_n = ~{i_sel[5], i_sel[0], i_sel[4:1]};
    assign o_val   = C_TBL[{w_idx_n, 2'b00} +: 4];
endmodule

module des_s2 (
    input  logic [5:0] i_sel,
    output logic [3:0] o_val
);
    localparam logic [255:0] C_TBL = {64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5,
                                      64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9};
    logic [5:0] w_idx_n;
    assign w_idx_n = ~{i_sel[5], i_sel[0], i_sel[4:1]};
    assign o_val   = C_TBL[{w_idx_n, 2'b00} +: 4];
endmodule

module des_s3 (
    input  logic [5:0] i_sel,
    output logic [3:0] o_val
);
    localparam logic [255:0] C_TBL = {64'hA09E63F51DC7B428, 64'hD709346A285ECBF1,
                                      64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C};
    logic [5:0] w_idx_n;
    assign w_idx_n = ~{i_sel[5], i_sel[0], i_sel[4:1]};
    assign o_val   = C_TBL[{w_idx_n, 2'b00} +: 4];
endmodule

module des_s4 (
    input  logic [5:0] i_sel,
    output logic [3:0] o_val
);
    localparam logic [255:0] C_TBL = {64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9,
                                      64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E};
    logic [5:0] w_idx_n;
    assign w_idx_n = ~{i_sel[5], i_sel[0], i_sel[4:1]};
    assign o_val   = C_TBL[{w_idx_n, 2'b00} +: 4];
endmodule

module des_s5 (
    input  logic [5:0] i_sel,
    output logic [3:0] o_val
);
    localparam logic [255:0] C_TBL = {64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986,
                                      64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453};
    logic [5:0] w_idx_n;
    assign w_idx_n = ~{i_sel[5], i_sel[0], i_sel[4:1]};
    assign o_val   = C_TBL[{w_idx_n, 2'b00} +: 4];
endmodule

module des_s6 (
    input  logic [5:0] i_sel,
    output logic [3:0] o_val
);
    localparam logic [255:0] C_TBL = {64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38,
                                      64'h9EF528C3704A1DB6, 64'h432C95FABE17608D};
    logic [5:0] w_idx_n;
    assign w_idx_n = ~{i_sel[5], i_sel[0], i_sel[4:1]};
    assign o_val   = C_TBL[{w_idx_n, 2'b00} +: 4];
endmodule

module des_s7 (
    input  logic [5:0] i_sel,
    output logic [3:0] o_val
);
    localparam logic [255:0] C_TBL = {64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86,
                                      64'h14BDC37EAF680592, 64'h6BD814A7950FE23C};
    logic [5:0] w_idx_n;
    assign w_idx_n = ~{i_sel[5], i_sel[0], i_sel[4:1]};
    assign o_val   = C_TBL[{w_idx_n, 2'b00} +: 4];
endmodule

module des_s8 (
    input  logic [5:0] i_sel,
    output logic [3:0] o_val
);
    localparam logic [255:0] C_TBL = {64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92,
                                      64'h7B419CE206ADF358, 64'h21E74A8DFC90356B};
    logic [5:0] w_idx_n;
    assign w_idx_n = ~{i_sel[5], i_sel[0], i_sel[4:1]};
    assign o_val   = C_TBL[{w_idx_n, 2'b00} +: 4];
endmodule

// ----------------------------------------------------------------------------
// Round engine
// ----------------------------------------------------------------------------
module des_iter_core (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        decrypt,
    input  logic [63:0] key,
    input  logic [63:0] din,
    output logic        busy,
    output logic        done,
    output logic [63:0] dout
);

    // Permutation tables in FIPS notation: entry i names the (1-based,
    // MSB-first) source bit for output bit i+1. Loops over constant tables
    // elaborate to pure wiring.
    localparam int C_IP [64] = '{58,50,42,34,26,18,10, 2, 60,52,44,36,28,20,12, 4,
                                 62,54,46,38,30,22,14, 6, 64,56,48,40,32,24,16, 8,
                                 57,49,41,33,25,17, 9, 1, 59,51,43,35,27,19,11, 3,
                                 61,53,45,37,29,21,13, 5, 63,55,47,39,31,23,15, 7};
    localparam int C_FP [64] = '{40, 8,48,16,56,24,64,32, 39, 7,47,15,55,23,63,31,
                                 38, 6,46,14,54,22,62,30, 37, 5,45,13,53,21,61,29,
                                 36, 4,44,12,52,20,60,28, 35, 3,43,11,51,19,59,27,
                                 34, 2,42,10,50,18,58,26, 33, 1,41, 9,49,17,57,25};
    localparam int C_E  [48] = '{32, 1, 2, 3, 4, 5,  4, 5, 6, 7, 8, 9,
                                  8, 9,10,11,12,13, 12,13,14,15,16,17,
                                 16,17,18,19,20,21, 20,21,22,23,24,25,
                                 24,25,26,27,28,29, 28,29,30,31,32, 1};
    localparam int C_P  [32] = '{16, 7,20,21,29,12,28,17,  1,15,23,26, 5,18,31,10,
                                  2, 8,24,14,32,27, 3, 9, 19,13,30, 6,22,11, 4,25};
    localparam int C_PC1[56] = '{57,49,41,33,25,17, 9,  1,58,50,42,34,26,18,
                                 10, 2,59,51,43,35,27, 19,11, 3,60,52,44,36,
                                 63,55,47,39,31,23,15,  7,62,54,46,38,30,22,
                                 14, 6,61,53,45,37,29, 21,13, 5,28,20,12, 4};
    localparam int C_PC2[48] = '{14,17,11,24, 1, 5,  3,28,15, 6,21,10,
                                 23,19,12, 4,26, 8, 16, 7,27,20,13, 2,
                                 41,52,31,37,47,55, 30,40,51,45,33,48,
                                 44,49,39,56,34,53, 46,42,50,36,29,32};

    function automatic logic [63:0] perm_ip(input logic [63:0] x);
        logic [63:0] o;
        o = '0;
        for (int i = 0; i < 64; i++) o[63-i] = x[64-C_IP[i]];
        return o;
    endfunction

    function automatic logic [63:0] perm_fp(input logic [63:0] x);
        logic [63:0] o;
        o = '0;
        for (int i = 0; i < 64; i++) o[63-i] = x[64-C_FP[i]];
        return o;
    endfunction

    function automatic logic [47:0] perm_e(input logic [31:0] x);
        logic [47:0] o;
        o = '0;
        for (int i = 0; i < 48; i++) o[47-i] = x[32-C_E[i]];
        return o;
    endfunction

    function automatic logic [31:0] perm_p(input logic [31:0] x);
        logic [31:0] o;
        o = '0;
        for (int i = 0; i < 32; i++) o[31-i] = x[32-C_P[i]];
        return o;
    endfunction

    function automatic logic [55:0] perm_pc1(input logic [63:0] x);
        logic [55:0] o;
        o = '0;
        for (int i = 0; i < 56; i++) o[55-i] = x[64-C_PC1[i]];
        return o;
    endfunction

    function automatic logic [47:0] perm_pc2(input logic [55:0] x);
        logic [47:0] o;
        o = '0;
        for (int i = 0; i < 48; i++) o[47-i] = x[56-C_PC2[i]];
        return o;
    endfunction

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_l;
    logic [31:0] r_r;
    logic [27:0] r_c;
    logic [27:0] r_d;
    logic [3:0]  r_cnt;
    logic        r_mode;
    logic        r_done;
    logic [63:0] r_dout;

    logic        w_load;
    logic        w_last;
    logic        w_enc_one;
    logic        w_dec_one;
    logic [27:0] w_c_rotl;
    logic [27:0] w_d_rotl;
    logic [27:0] w_c_rotr;
    logic [27:0] w_d_rotr;
    logic [55:0] w_cd_key;
    logic [47:0] w_subkey;
    logic [47:0] w_sin;
    logic [31:0] w_sout;
    logic [31:0] w_f;
    logic [31:0] w_r_nxt;
    logic        w_unused_parity;

    // Key parity bits (FIPS bits 8,16,...,64) never reach the schedule.
    assign w_unused_parity = ^{key[56], key[48], key[40], key[32],
                               key[24], key[16], key[8],  key[0]};

    // ------------------------------------------------------------------
    // Key schedule.
    // Encrypt round n=cnt+1 rotates left by s[n]; s[n]=1 for n=1,2,9,16.
    // Decrypt starts from C0||D0 (which equals the K16 state because the
    // total left rotation over 16 rounds is 28) and, after round j=cnt+1,
    // rotates right by s[17-j]; that amount is 1 for cnt=0,7,14,15.
    // ------------------------------------------------------------------
    assign w_enc_one = (r_cnt == 4'd0) || (r_cnt == 4'd1) ||
                       (r_cnt == 4'd8) || (r_cnt == 4'd15);
    assign w_dec_one = (r_cnt == 4'd0) || (r_cnt == 4'd7) ||
                       (r_cnt == 4'd14) || (r_cnt == 4'd15);

    assign w_c_rotl = w_enc_one ? {r_c[26:0], r_c[27]}    : {r_c[25:0], r_c[27:26]};
    assign w_d_rotl = w_enc_one ? {r_d[26:0], r_d[27]}    : {r_d[25:0], r_d[27:26]};
    assign w_c_rotr = w_dec_one ? {r_c[0],    r_c[27:1]}  : {r_c[1:0],  r_c[27:2]};
    assign w_d_rotr = w_dec_one ? {r_d[0],    r_d[27:1]}  : {r_d[1:0],  r_d[27:2]};

    assign w_cd_key = r_mode ? {r_c, r_d} : {w_c_rotl, w_d_rotl};
    assign w_subkey = perm_pc2(w_cd_key);

    // ------------------------------------------------------------------
    // Round function f(R, Kn) = P(S(E(R) xor Kn)).
    // ------------------------------------------------------------------
    assign w_sin = perm_e(r_r) ^ w_subkey;

    des_s1 u_s1 (.i_sel(w_sin[47:42]), .o_val(w_sout[31:28]));
    des_s2 u_s2 (.i_sel(w_sin[41:36]), .o_val(w_sout[27:24]));
    des_s3 u_s3 (.i_sel(w_sin[35:30]), .o_val(w_sout[23:20]));
    des_s4 u_s4 (.i_sel(w_sin[29:24]), .o_val(w_sout[19:16]));
    des_s5 u_s5 (.i_sel(w_sin[23:18]), .o_val(w_sout[15:12]));
    des_s6 u_s6 (.i_sel(w_sin[17:12]), .o_val(w_sout[11:8]));
    des_s7 u_s7 (.i_sel(w_sin[11:6]),  .o_val(w_sout[7:4]));
    des_s8 u_s8 (.i_sel(w_sin[5:0]),   .o_val(w_sout[3:0]));

    assign w_f     = perm_p(w_sout);
    assign w_r_nxt = r_l ^ w_f;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (r_cnt == 4'd15) begin
                    w_last      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Round datapath and result register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_l    <= '0;
            r_r    <= '0;
            r_c    <= '0;
            r_d    <= '0;
            r_cnt  <= '0;
            r_mode <= 1'b0;
            r_done <= 1'b0;
            r_dout <= '0;
        end else begin
            r_done <= w_last;
            if (w_load) begin
                {r_l, r_r} <= perm_ip(din);
                {r_c, r_d} <= perm_pc1(key);
                r_mode     <= decrypt;
                r_cnt      <= 4'd0;
            end else if (r_state == RUN) begin
                r_l   <= r_r;
                r_r   <= w_r_nxt;
                r_c   <= r_mode ? w_c_rotr : w_c_rotl;
                r_d   <= r_mode ? w_d_rotr : w_d_rotl;
                r_cnt <= r_cnt + 4'd1;
                // Final round: halves are swapped (R16||L16) before FP.
                if (w_last) begin
                    r_dout <= perm_fp({w_r_nxt, r_r});
                end
            end
        end
    end

    assign busy = (r_state == RUN);
    assign done = r_done;
    assign dout = r_dout;

endmodule

`default_nettype wire

// File: tb/tb_des_iter_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_des_iter_core
//  Description : Self-checking bench for des_iter_core. A behavioural DES
//                model (full subkey list, decrypt by reversed subkey order)
//                provides expected results for known-answer and random
//                vectors; handshake timing is checked cycle by cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_des_iter_core;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        decrypt = 1'b0;
    logic [63:0] key = '0;
    logic [63:0] din = '0;
    logic        busy;
    logic        done;
    logic [63:0] dout;

    int n_checks = 0;
    int n_fail   = 0;

    des_iter_core dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .decrypt (decrypt),
        .key     (key),
        .din     (din),
        .busy    (busy),
        .done    (done),
        .dout    (dout)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    int IP_T [64] = '{58,50,42,34,26,18,10, 2, 60,52,44,36,28,20,12, 4,
                      62,54,46,38,30,22,14, 6, 64,56,48,40,32,24,16, 8,
                      57,49,41,33,25,17, 9, 1, 59,51,43,35,27,19,11, 3,
                      61,53,45,37,29,21,13, 5, 63,55,47,39,31,23,15, 7};
    int FP_T [64] = '{40, 8,48,16,56,24,64,32, 39, 7,47,15,55,23,63,31,
                      38, 6,46,14,54,22,62,30, 37, 5,45,13,53,21,61,29,
                      36, 4,44,12,52,20,60,28, 35, 3,43,11,51,19,59,27,
                      34, 2,42,10,50,18,58,26, 33, 1,41, 9,49,17,57,25};
    int E_T  [48] = '{32, 1, 2, 3, 4, 5,  4, 5, 6, 7, 8, 9,  8, 9,10,11,12,13,
                      12,13,14,15,16,17, 16,17,18,19,20,21, 20,21,22,23,24,25,
                      24,25,26,27,28,29, 28,29,30,31,32, 1};
    int P_T  [32] = '{16, 7,20,21,29,12,28,17,  1,15,23,26, 5,18,31,10,
                       2, 8,24,14,32,27, 3, 9, 19,13,30, 6,22,11, 4,25};
    int PC1_T[56] = '{57,49,41,33,25,17, 9,  1,58,50,42,34,26,18,
                      10, 2,59,51,43,35,27, 19,11, 3,60,52,44,36,
                      63,55,47,39,31,23,15,  7,62,54,46,38,30,22,
                      14, 6,61,53,45,37,29, 21,13, 5,28,20,12, 4};
    int PC2_T[48] = '{14,17,11,24, 1, 5,  3,28,15, 6,21,10, 23,19,12, 4,26, 8,
                      16, 7,27,20,13, 2, 41,52,31,37,47,55, 30,40,51,45,33,48,
                      44,49,39,56,34,53, 46,42,50,36,29,32};
    int SHIFTS [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
    logic [255:0] SB [8] = '{
        {64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D},
        {64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9},
        {64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C},
        {64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E},
        {64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453},
        {64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D},
        {64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C},
        {64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B}};

    function automatic logic [3:0] sbox_ref(input int n, input logic [5:0] x);
        int row, col;
        logic [255:0] t;
        row = 2 * int'(x[5]) + int'(x[0]);
        col = int'(x[4:1]);
        t = SB[n] >> (4 * (63 - (row * 16 + col)));
        return t[3:0];
    endfunction

    function automatic logic [63:0] des_ref(input logic [63:0] k, input logic [63:0] blk,
                                            input logic dec);
        logic [27:0] c, d;
        logic [55:0] cd;
        logic [47:0] ks [16];
        logic [63:0] ipv, pre, res;
        logic [31:0] l, r, sout, f, tmp;
        logic [47:0] ex;
        cd = '0;
        for (int i = 0; i < 56; i++) cd[55-i] = k[64-PC1_T[i]];
        c = cd[55:28];
        d = cd[27:0];
        for (int rn = 0; rn < 16; rn++) begin
            for (int s = 0; s < SHIFTS[rn]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            cd = {c, d};
            for (int i = 0; i < 48; i++) ks[rn][47-i] = cd[56-PC2_T[i]];
        end
        ipv = '0;
        for (int i = 0; i < 64; i++) ipv[63-i] = blk[64-IP_T[i]];
        l = ipv[63:32];
        r = ipv[31:0];
        for (int rn = 0; rn < 16; rn++) begin
            ex = '0;
            for (int i = 0; i < 48; i++) ex[47-i] = r[32-E_T[i]];
            ex = ex ^ (dec ? ks[15-rn] : ks[rn]);
            sout = '0;
            for (int b = 0; b < 8; b++) sout[31-4*b -: 4] = sbox_ref(b, ex[47-6*b -: 6]);
            f = '0;
            for (int i = 0; i < 32; i++) f[31-i] = sout[32-P_T[i]];
            tmp = r;
            r = l ^ f;
            l = tmp;
        end
        pre = {r, l};
        res = '0;
        for (int i = 0; i < 64; i++) res[63-i] = pre[64-FP_T[i]];
        return res;
    endfunction

    // ------------------------------------------------------------------
    // Stimulus helper: issue one block, then report the result, the
    // number of cycles from the start edge to done (-1 on timeout) and
    // how many of those cycles showed busy.
    // ------------------------------------------------------------------
    task automatic do_block(input logic [63:0] k, input logic [63:0] d, input logic dec,
                            output logic [63:0] res, output int lat, output int busy_cyc);
        @(negedge clk);
        key = k; din = d; decrypt = dec; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        busy_cyc = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) busy_cyc++;
            @(posedge clk); #1;
            lat++;
        end
        res = dout;
        if (done !== 1'b1) lat = -1;
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_checks++;
        if (dout !== 64'h0) begin n_fail++; $display("FAIL reset_dout got %h want 0", dout); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_kat_encrypt();
        logic [63:0] res;
        int lat, bc;
        do_block(64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 1'b0, res, lat, bc);
        n_checks++;
        if (lat !== 16) begin n_fail++; $display("FAIL kat_enc_latency got %0d want 16", lat); end
        n_checks++;
        if (bc !== 16) begin n_fail++; $display("FAIL kat_enc_busy_cycles got %0d want 16", bc); end
        n_checks++;
        if (res !== 64'h85E813540F0AB405) begin
            n_fail++; $display("FAIL kat_enc_dout got %h want 85e813540f0ab405", res);
        end
        @(posedge clk); #1;
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL kat_enc_done_pulse got %b want 0", done); end
        n_checks++;
        if (dout !== 64'h85E813540F0AB405) begin
            n_fail++; $display("FAIL kat_enc_dout_hold got %h want 85e813540f0ab405", dout);
        end
    endtask

    task automatic test_kat_decrypt();
        logic [63:0] res;
        int lat, bc;
        do_block(64'h133457799BBCDFF1, 64'h85E813540F0AB405, 1'b1, res, lat, bc);
        n_checks++;
        if (res !== 64'h0123456789ABCDEF) begin
            n_fail++; $display("FAIL kat_dec_dout got %h want 0123456789abcdef", res);
        end
        n_checks++;
        if (lat !== 16) begin n_fail++; $display("FAIL kat_dec_latency got %0d want 16", lat); end
    endtask

    task automatic test_parity();
        logic [63:0] res;
        int lat, bc;
        do_block(64'h0E329232EA6D0D73, 64'h8787878787878787, 1'b0, res, lat, bc);
        n_checks++;
        if (res !== 64'h0) begin n_fail++; $display("FAIL parity_base got %h want 0", res); end
        // Put a nonzero result in dout first so the flipped-key run is observable.
        do_block(64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 1'b0, res, lat, bc);
        do_block(64'h0E329232EA6D0D73 ^ 64'h0101010101010101, 64'h8787878787878787,
                 1'b0, res, lat, bc);
        n_checks++;
        if (res !== 64'h0) begin n_fail++; $display("FAIL parity_flipped got %h want 0", res); end
    endtask

    task automatic test_busy_protect();
        logic [63:0] exp_v, got;
        int ndone, first;
        exp_v = des_ref(64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 1'b0);
        ndone = 0; first = -1; got = '0;
        @(negedge clk);
        key = 64'h133457799BBCDFF1; din = 64'h0123456789ABCDEF; decrypt = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        for (int c = 0; c < 30; c++) begin
            if (done === 1'b1) begin
                ndone++;
                if (first < 0) begin first = c; got = dout; end
            end
            if (c == 3 || c == 10) begin
                key = $urandom(); key[31:0] = $urandom();
                din = {$urandom(), $urandom()};
                decrypt = 1'b1;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (ndone !== 1) begin n_fail++; $display("FAIL busy_done_count got %0d want 1", ndone); end
        n_checks++;
        if (first !== 16) begin n_fail++; $display("FAIL busy_latency got %0d want 16", first); end
        n_checks++;
        if (got !== exp_v) begin n_fail++; $display("FAIL busy_result got %h want %h", got, exp_v); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] ka, da, kb, db, exp_a, exp_b;
        logic [63:0] got_a;
        int t, gap;
        logic hold_bad;
        ka = {$urandom(), $urandom()}; da = {$urandom(), $urandom()};
        kb = {$urandom(), $urandom()}; db = {$urandom(), $urandom()};
        exp_a = des_ref(ka, da, 1'b0);
        exp_b = des_ref(kb, db, 1'b1);
        @(negedge clk);
        key = ka; din = da; decrypt = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        key = kb; din = db; decrypt = 1'b1;   // start stays high throughout
        t = 0;
        while (done !== 1'b1 && t < 40) begin @(posedge clk); #1; t++; end
        got_a = dout;
        n_checks++;
        if (got_a !== exp_a) begin n_fail++; $display("FAIL b2b_first got %h want %h", got_a, exp_a); end
        gap = 0; hold_bad = 1'b0;
        @(posedge clk); #1;
        gap = 1;
        start = 1'b0;
        while (done !== 1'b1 && gap < 40) begin
            if (dout !== exp_a) hold_bad = 1'b1;
            @(posedge clk); #1;
            gap++;
        end
        n_checks++;
        if (gap !== 17) begin n_fail++; $display("FAIL b2b_gap got %0d want 17", gap); end
        n_checks++;
        if (hold_bad !== 1'b0) begin n_fail++; $display("FAIL b2b_dout_hold got %b want 0", hold_bad); end
        n_checks++;
        if (dout !== exp_b) begin n_fail++; $display("FAIL b2b_second got %h want %h", dout, exp_b); end
    endtask

    task automatic test_reset_abort();
        logic [63:0] res, exp_v;
        int lat, bc, spurious;
        @(negedge clk);
        key = {$urandom(), $urandom()}; din = {$urandom(), $urandom()}; decrypt = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b want 0", busy); end
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done got %b want 0", done); end
        n_checks++;
        if (dout !== 64'h0) begin n_fail++; $display("FAIL abort_dout got %h want 0", dout); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        spurious = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) spurious++;
        end
        n_checks++;
        if (spurious !== 0) begin n_fail++; $display("FAIL abort_spurious got %0d want 0", spurious); end
        exp_v = des_ref(64'h0E329232EA6D0D73, 64'h0123456789ABCDEF, 1'b0);
        do_block(64'h0E329232EA6D0D73, 64'h0123456789ABCDEF, 1'b0, res, lat, bc);
        n_checks++;
        if (res !== exp_v) begin n_fail++; $display("FAIL abort_after got %h want %h", res, exp_v); end
    endtask

    task automatic test_random();
        logic [63:0] k, d, res, exp_v;
        logic dec;
        int lat, bc;
        for (int i = 0; i < 12; i++) begin
            k = {$urandom(), $urandom()};
            d = {$urandom(), $urandom()};
            dec = 1'($urandom_range(0, 1));
            exp_v = des_ref(k, d, dec);
            do_block(k, d, dec, res, lat, bc);
            n_checks++;
            if (res !== exp_v) begin
                n_fail++; $display("FAIL random_%0d dec=%b got %h want %h", i, dec, res, exp_v);
            end
            n_checks++;
            if (lat !== 16) begin n_fail++; $display("FAIL random_%0d_latency got %0d want 16", i, lat); end
        end
    endtask

    initial begin
        test_reset();
        test_kat_encrypt();
        test_kat_decrypt();
        test_parity();
        test_busy_protect();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
